// File: rtl/dbg_bridge_uart_tx.sv
// 8N1 UART transmitter that drains a show-ahead byte FIFO. The first start bit appears one
// clock after a pop from idle. A waiting byte is popped in the last stop-bit cycle, so frames run back to back.
module dbg_bridge_uart_tx #(
    parameter int CLK_DIV = 434,
    parameter int DIV_W   = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       pop_o,
    output logic       txd_o,
    output logic       busy_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [1:0]       state_q;
    logic [7:0]       shift_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       bit_q;
    logic             txd_q;
    logic             div_done;

    assign div_done = (div_q == '0);
    assign pop_o    = valid_i & rst_i &
                      ((state_q == S_IDLE) | ((state_q == S_STOP) & div_done));
    assign txd_o    = txd_q;
    assign busy_o   = (state_q != S_IDLE);

    // txd_q is loaded with the level of the state being entered, so the line is glitch-free
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            shift_q <= 8'h00;
            div_q   <= '0;
            bit_q   <= 3'd0;
            txd_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop_o) begin
                        shift_q <= data_i;
                        div_q   <= DIV_LAST;
                        state_q <= S_START;
                        txd_q   <= 1'b0;
                    end
                end
                S_START: begin
                    if (div_done) begin
                        div_q   <= DIV_LAST;
                        bit_q   <= 3'd0;
                        state_q <= S_DATA;
                        txd_q   <= shift_q[0];
                    end else begin
                        div_q <= div_q - DIV_ONE;
                    end
                end
                S_DATA: begin
                    if (div_done) begin
                        shift_q <= {1'b0, shift_q[7:1]};
                        div_q   <= DIV_LAST;
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                            txd_q   <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            txd_q <= shift_q[1];
                        end
                    end else begin
                        div_q <= div_q - DIV_ONE;
                    end
                end
                S_STOP: begin
                    if (div_done) begin
                        if (pop_o) begin
                            shift_q <= data_i;
                            div_q   <= DIV_LAST;
                            state_q <= S_START;
                            txd_q   <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            txd_q   <= 1'b1;
                        end
                    end else begin
                        div_q <= div_q - DIV_ONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_bridge_uart_tx.sv
// Directed bench: three transmitters (dividers 4, 8, 2) fed from bench-side FIFOs,
// watched by a UART decoder that records pop times, start-bit times and received bytes.
module tb_dbg_bridge_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] vld;
    logic [7:0] din [3];
    logic [2:0] pop, txd, busy;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    logic [7:0] mem [3][512];
    logic [7:0] dec [3][512];
    int         pt  [3][512];
    int         st  [3][512];
    int         wr [3], rd [3], pcnt [3], scnt [3], dn [3], dctr [3];
    bit         pend [3], dact [3];
    logic [7:0] dsh [3];
    int         ferr = 0;

    dbg_bridge_uart_tx #(.CLK_DIV(4), .DIV_W(16)) u_div4 (
        .clk_i(clk), .rst_i(rst), .data_i(din[0]), .valid_i(vld[0]),
        .pop_o(pop[0]), .txd_o(txd[0]), .busy_o(busy[0]));
    dbg_bridge_uart_tx #(.CLK_DIV(8), .DIV_W(16)) u_div8 (
        .clk_i(clk), .rst_i(rst), .data_i(din[1]), .valid_i(vld[1]),
        .pop_o(pop[1]), .txd_o(txd[1]), .busy_o(busy[1]));
    dbg_bridge_uart_tx #(.CLK_DIV(2), .DIV_W(16)) u_div2 (
        .clk_i(clk), .rst_i(rst), .data_i(din[2]), .valid_i(vld[2]),
        .pop_o(pop[2]), .txd_o(txd[2]), .busy_o(busy[2]));

    always #5 clk = ~clk;

    function automatic int div_of(input int ch);
        return (ch == 0) ? 4 : (ch == 1) ? 8 : 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input int ch, input logic [7:0] b);
        mem[ch][wr[ch]] = b;
        wr[ch]++;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // FIFO model and UART decoder; both update on the falling edge
    initial forever begin
        @(negedge clk);
        for (int ch = 0; ch < 3; ch++) begin
            if (pend[ch]) begin
                rd[ch]++;
                pend[ch] = 1'b0;
            end
            vld[ch] = (rd[ch] != wr[ch]);
            din[ch] = mem[ch][rd[ch] % 512];
        end
        #1;
        for (int ch = 0; ch < 3; ch++) begin
            int d;
            d = div_of(ch);
            if (pop[ch]) begin
                pt[ch][pcnt[ch]] = cyc;
                pcnt[ch]++;
                pend[ch] = 1'b1;
            end
            if (!rst) begin
                dact[ch] = 1'b0;
            end else if (!dact[ch]) begin
                if (!txd[ch]) begin
                    dact[ch] = 1'b1;
                    dctr[ch] = 0;
                    st[ch][scnt[ch]] = cyc;
                    scnt[ch]++;
                end
            end else begin
                dctr[ch]++;
                if (dctr[ch] >= d && dctr[ch] < 9 * d && (dctr[ch] % d) == d / 2)
                    dsh[ch][dctr[ch] / d - 1] = txd[ch];
                if (dctr[ch] == 9 * d + d / 2) begin
                    if (txd[ch]) begin
                        dec[ch][dn[ch]] = dsh[ch];
                        dn[ch]++;
                    end else begin
                        ferr++;
                    end
                    dact[ch] = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [7:0] a5;
        int bad;
        int cv;
        a5 = 8'hA5;
        rst = 1'b0;
        vld = 3'b000;
        for (int ch = 0; ch < 3; ch++) begin
            din[ch] = 8'h00; wr[ch] = 0; rd[ch] = 0; pcnt[ch] = 0;
            scnt[ch] = 0; dn[ch] = 0; dctr[ch] = 0; pend[ch] = 1'b0;
            dact[ch] = 1'b0; dsh[ch] = 8'h00;
        end

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_txd", txd, 3'b111);
        check("reset_pop", pop, 3'b000);
        check("reset_busy", busy, 3'b000);
        @(negedge clk);
        rst = 1'b1;

        // single byte 0xA5, divider 4: 10 levels of 4 cycles each
        @(posedge clk); #1;
        push(0, 8'hA5);
        @(posedge clk); #1;
        check("single_pop_cnt", pcnt[0], 1);
        check("single_busy_start", busy[0], 1'b1);
        for (int k = 0; k < 40; k++) begin
            logic lvl;
            int b;
            b = k / 4;
            if (b == 0)      lvl = 1'b0;
            else if (b == 9) lvl = 1'b1;
            else             lvl = a5[b - 1];
            check($sformatf("single_txd_c%0d", k), txd[0], lvl);
            @(posedge clk); #1;
        end
        check("single_end_busy", busy[0], 1'b0);
        check("single_end_txd", txd[0], 1'b1);
        check("single_pop_total", pcnt[0], 1);
        check("single_dec_cnt", dn[0], 1);
        check("single_dec_byte", dec[0][0], 8'hA5);
        check("single_pop_to_start", st[0][0] - pt[0][0], 1);

        // idle: nothing presented for 1000 cycles
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (pop !== 3'b000 || txd !== 3'b111 || busy !== 3'b000) bad++;
        end
        check("idle_quiet_cycles_bad", bad, 0);

        // back-to-back 0x00, 0xFF, 0x3C with divider 4
        @(posedge clk); #1;
        push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h3C);
        repeat (135) @(posedge clk);
        #1;
        check("b2b_pop_cnt", pcnt[0], 4);
        check("b2b_pop_gap1", pt[0][2] - pt[0][1], 40);
        check("b2b_pop_gap2", pt[0][3] - pt[0][2], 40);
        check("b2b_start_cnt", scnt[0], 4);
        check("b2b_start_gap1", st[0][2] - st[0][1], 40);
        check("b2b_start_gap2", st[0][3] - st[0][2], 40);
        check("b2b_byte0", dec[0][1], 8'h00);
        check("b2b_byte1", dec[0][2], 8'hFF);
        check("b2b_byte2", dec[0][3], 8'h3C);
        check("b2b_busy_end", busy[0], 1'b0);

        // mid-frame reset during data bit 3 of 0x55, divider 8
        @(posedge clk); #1;
        push(1, 8'h55);
        @(posedge clk);
        repeat (34) @(posedge clk);
        #1;
        check("rst_pre_bit3", txd[1], 1'b0);
        check("rst_pre_busy", busy[1], 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_txd", txd[1], 1'b1);
        check("rst_async_busy", busy[1], 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        push(1, 8'h81);
        @(negedge clk); #2;
        cv = cyc;
        @(posedge clk); #1;
        check("rst_new_start_latency", txd[1], 1'b0);
        repeat (85) @(posedge clk);
        #1;
        check("rst_pop_cnt", pcnt[1], 2);
        check("rst_dec_cnt", dn[1], 1);
        check("rst_dec_byte", dec[1][0], 8'h81);
        check("rst_start_cycle", st[1][scnt[1] - 1] - cv, 1);
        check("rst_busy_end", busy[1], 1'b0);

        // 256 random bytes streamed with divider 2
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) push(2, 8'($urandom_range(0, 255)));
        repeat (256 * 20 + 40) @(posedge clk);
        #1;
        check("stream_pop_cnt", pcnt[2], 256);
        check("stream_dec_cnt", dn[2], 256);
        bad = 0;
        for (int i = 0; i < 256; i++) if (dec[2][i] !== mem[2][i]) bad++;
        check("stream_bytes_bad", bad, 0);
        bad = 0;
        for (int i = 1; i < 256; i++) begin
            if (st[2][i] - st[2][i - 1] != 20) bad++;
            if (pt[2][i] - pt[2][i - 1] != 20) bad++;
        end
        check("stream_frame_len_bad", bad, 0);
        check("stream_busy_end", busy[2], 1'b0);
        check("framing_errors", ferr, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dbg_bridge_uart_tx.md
# dbg_bridge_uart_tx

UART transmitter for the debug bridge, draining the bridge's byte-wide transmit FIFO directly downstream of it. It reads bytes from a show-ahead FIFO interface (data visible while valid, consumed on a one-cycle pop) and serialises each byte as an 8N1 frame on txd_o. Baud timing comes from a fixed clock-divider parameter. There is no flow control and no run-time configuration.

## Interface
Parameters:
- CLK_DIV, default 434: clk_i cycles per UART bit (434 gives 115200 baud at 50 MHz). Legal values are 2..65535.
- DIV_W, default 16: width of the baud counter. Must satisfy 2^DIV_W > CLK_DIV.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset, asynchronous, active-low.
- data_i, in, 8: byte at the FIFO head. Valid only while valid_i=1.
- valid_i, in, 1: FIFO non-empty.
- pop_o, out, 1: consume the FIFO head this cycle.
- txd_o, out, 1: serial output. Idle level is 1.
- busy_o, out, 1: a frame is in progress (state != IDLE).

## Operation
- States: IDLE, START, DATA, STOP.
- Registers:
  - shift_q[7:0]
  - div_q[DIV_W-1:0], counting down from CLK_DIV-1 to 0
  - bit_q[2:0]
  - txd_q
- pop_o = valid_i & rst_i & (IDLE | (STOP & div_q==0)). It is combinational, so the FIFO pops on the same clock edge that data_i is captured.
- IDLE:
  - txd_o=1.
  - On pop_o: shift_q<=data_i, div_q<=CLK_DIV-1, go to START.
- START:
  - txd_o=0.
  - When div_q==0: div_q<=CLK_DIV-1, bit_q<=0, go to DATA.
  - Otherwise div_q decrements.
- DATA:
  - txd_o=shift_q[0]. Bits are sent LSB first.
  - When div_q==0: shift_q shifts right by 1 and div_q reloads.
    - If bit_q==7, go to STOP.
    - Otherwise bit_q increments.
- STOP:
  - txd_o=1.
  - When div_q==0:
    - If pop_o, load the new byte and go to START. This is the back-to-back case with no idle gap.
    - Otherwise go to IDLE.
- txd_o is driven from a register (txd_q), not decoded combinationally. No glitches are allowed.
- Frame length is exactly 10*CLK_DIV cycles.
- pop_o is never asserted while valid_i=0. data_i is ignored in every cycle where pop_o=0.
- Reset, asynchronous, including mid-frame:
  - state=IDLE, txd_q=1, shift_q=0, div_q=0, bit_q=0.
  - The frame in progress is abandoned. The byte already popped is lost.
  - txd_o returns to 1 immediately, without waiting for a clock edge.

## Timing
- Reset values: txd_o=1, pop_o=0, busy_o=0.
- Cycle numbering: call the edge at which IDLE and valid_i=1 is sampled edge E0, where pop_o=1 in the preceding cycle.
  - txd_o falls to 0 after E0.
  - The start bit occupies cycles E0..E0+CLK_DIV-1.
  - Data bit n occupies cycles E0+(n+1)*CLK_DIV onward.
  - The stop bit starts at E0+9*CLK_DIV.
- Back-to-back: with valid_i held at 1, the next pop_o occurs in the last stop-bit cycle. The next start bit begins exactly 10*CLK_DIV cycles after the previous one.
- From IDLE, latency from valid_i rising to the txd_o falling edge is 1 clock.
- busy_o is 1 from the cycle after a pop from IDLE until the cycle after the STOP exit to IDLE. It stays 1 across back-to-back frames.
- Each pop_o pulse is exactly 1 cycle wide. At most one pop occurs per frame.

## Test plan
- Single byte: CLK_DIV=4, present 0xA5 once.
  - Required: one pop_o pulse.
  - txd_o shows 0, then 1,0,1,0,0,1,0,1, then 1, each level held 4 cycles.
  - 40 cycles in total, then IDLE with busy_o=0.
- Back-to-back: CLK_DIV=4, FIFO preloaded with 0x00, 0xFF, 0x3C.
  - Required: pops spaced exactly 40 cycles apart.
  - Start bits 40 cycles apart, with no extra idle high between frames.
  - Decoded bytes are 0x00, 0xFF, 0x3C.
- Idle: valid_i=0 for 1000 cycles.
  - Required: pop_o=0, txd_o=1, busy_o=0 throughout.
- Mid-frame reset: CLK_DIV=8, byte 0x55; assert rst_i low during data bit 3, for 3 cycles.
  - Required: txd_o=1 asynchronously, busy_o=0.
  - After release, with a new byte 0x81, a clean full frame for 0x81 is sent, starting 1 cycle after its valid.
- Minimum divider: CLK_DIV=2, 256 random bytes streamed.
  - Required: every frame is 20 cycles.
  - A bench UART model decodes all 256 bytes in order.
  - Pop count equals 256.
